// File: rtl/gte_flag_sequencer_if.sv
// Bundle between the GTE flag sequencer and its command/checker/CPU environment.
// Optional GTE_FLAG_STATS_EN adds the error-count clear and counter signals.
interface gte_flag_sequencer_if #(parameter int unsigned TGT_W = 4);
   logic             i_start;
   logic             i_cmdSF;
   logic             i_cmdLM;
   logic             i_cmdIR3Quirk;
   logic             i_chkValid;
   logic [TGT_W-1:0] i_target;
   logic             i_AxPos;
   logic             i_AxNeg;
   logic             i_FPos;
   logic             i_FNeg;
   logic             i_G;
   logic             i_H;
   logic             i_B;
   logic             i_C;
   logic             i_D;
   logic             i_divOvf;
   logic             i_end;
   logic             i_flagWr;
   logic [31:0]      i_flagWrData;
   logic             o_sf;
   logic             o_lm;
   logic             o_forceSF_BFlag;
   logic             o_busy;
   logic             o_done;
   logic [31:0]      o_flag;
`ifdef GTE_FLAG_STATS_EN
   logic             i_errCountClr;
   logic [15:0]      o_errCount;

   modport slave (
      input  i_start, i_cmdSF, i_cmdLM, i_cmdIR3Quirk, i_chkValid, i_target,
             i_AxPos, i_AxNeg, i_FPos, i_FNeg, i_G, i_H, i_B, i_C, i_D,
             i_divOvf, i_end, i_flagWr, i_flagWrData, i_errCountClr,
      output o_sf, o_lm, o_forceSF_BFlag, o_busy, o_done, o_flag, o_errCount
   );
   modport master (
      output i_start, i_cmdSF, i_cmdLM, i_cmdIR3Quirk, i_chkValid, i_target,
             i_AxPos, i_AxNeg, i_FPos, i_FNeg, i_G, i_H, i_B, i_C, i_D,
             i_divOvf, i_end, i_flagWr, i_flagWrData, i_errCountClr,
      input  o_sf, o_lm, o_forceSF_BFlag, o_busy, o_done, o_flag, o_errCount
   );
`else
   modport slave (
      input  i_start, i_cmdSF, i_cmdLM, i_cmdIR3Quirk, i_chkValid, i_target,
             i_AxPos, i_AxNeg, i_FPos, i_FNeg, i_G, i_H, i_B, i_C, i_D,
             i_divOvf, i_end, i_flagWr, i_flagWrData,
      output o_sf, o_lm, o_forceSF_BFlag, o_busy, o_done, o_flag
   );
   modport master (
      output i_start, i_cmdSF, i_cmdLM, i_cmdIR3Quirk, i_chkValid, i_target,
             i_AxPos, i_AxNeg, i_FPos, i_FNeg, i_G, i_H, i_B, i_C, i_D,
             i_divOvf, i_end, i_flagWr, i_flagWrData,
      input  o_sf, o_lm, o_forceSF_BFlag, o_busy, o_done, o_flag
   );
`endif
endinterface

// File: rtl/gte_flag_sequencer.sv
// Drives the shared GTE overflow checker per result and accumulates the sticky FLAG register.
// Optional GTE_FLAG_STATS_EN adds a saturating count of commands that ended with FLAG[31] set.
module gte_flag_sequencer #(
   parameter int unsigned TGT_W = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   gte_flag_sequencer_if.slave  bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t      r_state;
   logic        r_busy;
   logic        r_done;
   logic        r_cfgSF;
   logic        r_cfgLM;
   logic        r_cfgQuirk;
   logic [30:12] r_flag;
   logic [30:12] w_set;
   logic        w_err;
   logic        w_tgtIR;
   logic        w_unused_wr;

   assign w_unused_wr = ^{bus.i_flagWrData[31], bus.i_flagWrData[11:0]};

   // Map the checker's flags for the current target onto FLAG bit positions
   always_comb begin
      w_set = '0;
      if (bus.i_chkValid) begin
         case (bus.i_target)
            TGT_W'(0):  begin w_set[30] = bus.i_AxPos; w_set[27] = bus.i_AxNeg; end
            TGT_W'(1):  begin w_set[29] = bus.i_AxPos; w_set[26] = bus.i_AxNeg; end
            TGT_W'(2):  begin w_set[28] = bus.i_AxPos; w_set[25] = bus.i_AxNeg; end
            TGT_W'(3):  w_set[24] = bus.i_B;
            TGT_W'(4):  w_set[23] = bus.i_B;
            TGT_W'(5):  w_set[22] = bus.i_B;
            TGT_W'(6):  begin w_set[16] = bus.i_FPos; w_set[15] = bus.i_FNeg; end
            TGT_W'(7):  w_set[14] = bus.i_G;
            TGT_W'(8):  w_set[13] = bus.i_G;
            TGT_W'(9):  w_set[12] = bus.i_H;
            TGT_W'(10): w_set[18] = bus.i_D;
            TGT_W'(11): w_set[21] = bus.i_C;
            TGT_W'(12): w_set[20] = bus.i_C;
            TGT_W'(13): w_set[19] = bus.i_C;
            TGT_W'(14): w_set[17] = bus.i_divOvf;
            default:    w_set = '0;
         endcase
      end
   end

   assign w_tgtIR             = (bus.i_target >= TGT_W'(3)) && (bus.i_target <= TGT_W'(5));
   assign bus.o_sf            = r_cfgSF;
   assign bus.o_lm            = r_cfgLM & w_tgtIR;
   assign bus.o_forceSF_BFlag = r_cfgQuirk & (bus.i_target == TGT_W'(5));

   // IR3, R, G, B and IR0 do not contribute to the error summary
   assign w_err      = (|r_flag[30:23]) | (|r_flag[18:13]);
   assign bus.o_flag = {w_err, r_flag, 12'h000};
   assign bus.o_busy = r_busy;
   assign bus.o_done = r_done;

   // Command sequencing, config latch and FLAG update (start > CPU write > check)
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_cfgSF    <= 1'b0;
         r_cfgLM    <= 1'b0;
         r_cfgQuirk <= 1'b0;
         r_flag     <= '0;
      end else if (bus.i_start) begin
         r_state    <= ST_RUN;
         r_busy     <= 1'b1;
         r_done     <= 1'b0;
         r_cfgSF    <= bus.i_cmdSF;
         r_cfgLM    <= bus.i_cmdLM;
         r_cfgQuirk <= bus.i_cmdIR3Quirk;
         r_flag     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_busy <= 1'b0;
               r_done <= 1'b0;
            end
            ST_RUN: begin
               if (bus.i_end) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
         if (bus.i_flagWr) begin
            r_flag <= bus.i_flagWrData[30:12];
         end else if (r_state == ST_RUN) begin
            r_flag <= r_flag | w_set;
         end
      end
   end

`ifdef GTE_FLAG_STATS_EN
   logic [15:0] r_errCount;

   // Saturating count of commands completing with the error summary set
   always_ff @(posedge i_clk) begin
      if (i_rst || bus.i_errCountClr) begin
         r_errCount <= '0;
      end else if ((r_state == ST_DONE) && w_err && (r_errCount != 16'hFFFF)) begin
         r_errCount <= r_errCount + 16'd1;
      end
   end

   assign bus.o_errCount = r_errCount;
`endif
endmodule

// File: doc/gte_flag_sequencer.md
Name: gte_flag_sequencer

Overview:
Sequences the shared GTE overflow/saturation checker across the results of one GTE command. For each checked result it drives the checker's sf/lm/forceSF_BFlag controls from the active command configuration and the current target. It maps the returned flags into the architectural FLAG register and accumulates them (sticky OR) over the command. It also handles command start/end, computes the error summary bit 31, and supports CPU read/write of FLAG.

Parameters:
TGT_W, 4, width of the check-target selector.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_start  in  1  pulse: new command; clears FLAG, latches config
i_cmdSF  in  1  command sf bit
i_cmdLM  in  1  command lm bit
i_cmdIR3Quirk  in  1  force sf=1 for the IR3 B flag (RTPS/RTPT behaviour)
i_chkValid  in  1  a checker result is present this cycle
i_target  in  TGT_W  result being checked: 0-2 MAC1-3, 3-5 IR1-3, 6 MAC0, 7 SX2, 8 SY2, 9 IR0, 10 SZ3/OTZ, 11 R, 12 G, 13 B, 14 DIV, 15 reserved
i_AxPos,i_AxNeg,i_FPos,i_FNeg,i_G,i_H,i_B,i_C,i_D  in  1 each  checker flag outputs
i_divOvf  in  1  divider overflow flag
i_end  in  1  pulse: last check of the command
i_flagWr  in  1  CPU write strobe
i_flagWrData  in  32  CPU write data
o_sf  out  1  to checker sf
o_lm  out  1  to checker lm
o_forceSF_BFlag  out  1  to checker forceSF_BFlag
o_busy  out  1  state==RUN
o_done  out  1  one-cycle pulse, command complete
o_flag  out  32  architectural FLAG register

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_rst. Reset sets state IDLE, flag[30:12]=0, config regs=0, o_done=0, o_flag=0.
- States:
  - IDLE -(i_start)-> RUN.
  - RUN -(i_end)-> DONE.
  - DONE is always exactly one cycle, then -> IDLE; o_done=1 only while in DONE.
  - i_start in any state, including RUN or DONE, re-enters RUN and clears flag[30:12] that cycle.
- Config latch: on i_start, the cfg regs sf/lm/quirk are loaded from i_cmd*.
- Checker control outputs (combinational from cfg and i_target, same cycle as the check):
  - o_sf = cfgSF.
  - o_lm = cfgLM when i_target in 3..5, else 0.
  - o_forceSF_BFlag = cfgQuirk when i_target==5, else 0.
- Flag accumulation: only in RUN with i_chkValid. The register ORs in the mapped bit(s):
  - MACn: bit (31-n) |= FPos|AxPos... More precisely, MAC1/2/3 use the 43-bit test: bit 30/29/28 |= AxPos, bit 27/26/25 |= AxNeg.
  - IR1/2/3: bit 24/23/22 |= B.
  - R/G/B: bit 21/20/19 |= C.
  - SZ3/OTZ: bit 18 |= D.
  - DIV: bit 17 |= i_divOvf.
  - MAC0: bit 16 |= FPos, bit 15 |= FNeg.
  - SX2: bit 14 |= G. SY2: bit 13 |= G.
  - IR0: bit 12 |= H.
  - Target 15 ignored.
  - Flags take effect on the next cycle. A check coinciding with i_end is included.
- o_flag:
  - o_flag[11:0]=0.
  - o_flag[30:12]=register.
  - o_flag[31] = |reg[30:23] | |reg[18:13], combinational from the register. IR3, R, G, B and IR0 are excluded.
- CPU write: i_flagWr loads reg[30:12] from i_flagWrData[30:12]. Data bits 31 and 11:0 are ignored. The write is accepted in any state and does not change state.
- Priority in one cycle: i_rst > i_start > i_flagWr > check accumulation.
  - i_start with i_flagWr: the register is cleared.
  - i_flagWr with a check: the check is dropped.
- i_chkValid or i_end outside RUN: ignored.

Optional Feature:
GTE_FLAG_STATS_EN:
- Adds output o_errCount (16 bits) and input i_errCountClr (1 bit).
- o_errCount increments in the DONE cycle when o_flag[31]=1 and saturates at 16'hFFFF.
- i_errCountClr and reset zero the counter. i_errCountClr has priority over an increment in the same cycle.
- Without the macro, neither port nor the counter exists.

Test Plan:
- Reset, then idle -> o_flag=0, o_busy=0, o_done=0, o_sf=o_lm=o_forceSF_BFlag=0.
- i_start(sf=1,lm=1,quirk=1) followed by checks:
  - target 4 -> o_sf=1, o_lm=1, o_forceSF_BFlag=0.
  - target 5 -> o_forceSF_BFlag=1.
  - target 0 -> o_lm=0.
- RUN with target 0 AxPos=1, then i_end -> o_flag=32'hC0000000, o_done pulses one cycle after i_end, o_busy low after that.
- RUN with only target 5 B=1 plus target 9 H=1 -> o_flag=32'h00401000, bit31=0.
- RUN with target 7 G=1, then target 7 G=0 -> bit 14 stays set (sticky). i_start the next cycle -> o_flag=0.
- i_flagWr with data 32'hFFFFFFFF while a target 1 check is pending -> o_flag=32'hFFFFF000 and the check is dropped. i_flagWr with data 32'h00400000 -> o_flag=32'h00400000.
